fir_filter_seq_ctrl: RTL and testbench
======================================

# fir_filter_seq_ctrl

Sequencer for the 3-phase FIR input-control datapath. It accepts a frame of sample beats through a valid/ready handshake and drives the datapath's phase select `cnt_mod` and advance enable `tc_write`. It flags when the 9-tap window is fully populated and signals frame completion after a programmable drain. It sits between the AHB-side sample source and `fir_filter_input_control`, and owns all sequencing of that datapath.

## Interface
- `LEN_W`, default 16: width of the frame-length field.
- `FILL_BEATS`, default 3: beats needed before the tap window is full.
- `DRAIN_CYCLES`, default 2: downstream MAC latency waited after the last beat; legal range 0..15.

- `clk`, input, 1: single clock; all state changes on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: frame start request; sampled only in IDLE.
- `frame_len`, input, LEN_W: number of beats in the frame; latched on accepted `start`.
- `abort`, input, 1: synchronous frame cancel.
- `in_valid`, input, 1: source has a beat on the datapath inputs.
- `in_ready`, output, 1: controller accepts a beat this cycle.
- `cnt_mod`, output, 2: datapath phase select, 0/1/2; registered.
- `tc_write`, output, 1: datapath advance enable; equals `in_valid & in_ready`.
- `tap_valid`, output, 1: the window just written is complete; registered, 1-cycle pulse per beat.
- `tap_phase`, output, 2: phase written on the beat that `tap_valid` refers to.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: 1-cycle pulse at frame completion.

## Operation
- Datapath contract: all datapath registers update only on cycles with `tc_write=1`, so source stalls are lossless.
- States:
  - IDLE: `in_ready=0`; `cnt_mod` held at 0.
  - FILL: `in_ready=1`; fewer than FILL_BEATS beats accepted.
  - RUN: `in_ready=1`; at least FILL_BEATS beats accepted.
  - DRAIN: `in_ready=0`; counts down DRAIN_CYCLES.
  - DONE: asserts `done`.
- Transitions:
  - IDLE→FILL on `start=1` with `frame_len≠0`. `start` with `frame_len=0` is ignored: no state change, no `done`. `start` outside IDLE is ignored.
  - FILL→RUN when the accepted-beat count reaches FILL_BEATS and beats remain.
  - FILL or RUN→DRAIN on acceptance of beat number `frame_len`. This applies from FILL for frames shorter than FILL_BEATS.
  - DRAIN→DONE after DRAIN_CYCLES cycles. With DRAIN_CYCLES=0, the transition is direct to DONE.
  - DONE→IDLE unconditionally after 1 cycle.
- Accept occurs when `in_valid & in_ready`. On each accept:
  - `cnt_mod` advances 0→1→2→0 (wraps at 2, never reaches 3).
  - The remaining-beat counter decrements.
  - The accepted-beat counter increments, saturating at FILL_BEATS.
- `tap_valid` pulses the cycle after an accept whose post-increment count is ≥FILL_BEATS. `tap_phase` is the `cnt_mod` value used on that accept.
- `abort` in any non-IDLE state forces IDLE on the next edge. It clears `cnt_mod` and the counters, produces no `done` and no `tap_valid`, and any beat presented that cycle is not accepted (`in_ready` forced 0). `abort` in IDLE has no effect.
- `abort` and `start` together in IDLE: `abort` wins, `start` is ignored.
- Counters are LEN_W bits. `frame_len` up to 2^LEN_W−1 is supported with no wrap of the remaining-beat counter.

## Timing
- Reset (asynchronous assert): state IDLE, `cnt_mod=0`, `in_ready=0`, `tc_write=0`, `tap_valid=0`, `tap_phase=0`, `busy=0`, `done=0`, all counters 0.
- `start` sampled in cycle S: `busy=1` and `in_ready=1` from S+1.
- Accept in cycle N with `cnt_mod=k`: `tc_write=1` in N; `cnt_mod=(k+1) mod 3` in N+1; `tap_valid`/`tap_phase=k` in N+1 when the window is full.
- Last beat accepted in cycle L:
  - `in_ready=0` from L+1.
  - `tap_valid` for that beat in L+1.
  - `done=1` in L+DRAIN_CYCLES+1 only.
  - `busy=0` from L+DRAIN_CYCLES+2.
- `start` is earliest re-accepted in the first IDLE cycle. Minimum frame-to-frame gap is DRAIN_CYCLES+2 cycles.
- Throughput: 1 beat per cycle while `in_valid` is held high. A bubble on `in_valid` stalls `cnt_mod` and produces no `tap_valid`.

## Test plan
- Reset mid-frame: assert `rst_n=0` during RUN with `cnt_mod=2` → all outputs 0 immediately; `busy=0`; next `start` begins at `cnt_mod=0`.
- Frame of 7 beats, continuous `in_valid`, DRAIN_CYCLES=2:
  - `cnt_mod` sequence 0,1,2,0,1,2,0.
  - `tap_valid` on 5 cycles, with `tap_phase` 2,0,1,2,0.
  - `done` exactly 3 cycles after the 7th accept.
- Frame of 6 beats with `in_valid` low on every other cycle → `cnt_mod` advances only on accepts; `tc_write` count = 6; `tap_valid` count = 4; no extra `done`.
- Frame of 2 beats → no `tap_valid`; `done` at L+3. A `start` with `frame_len=0` is ignored (`busy` stays 0).
- `abort` on the cycle of the 4th accept of a 10-beat frame → that beat is not accepted (`tc_write=0`); IDLE next cycle; no `done`; `cnt_mod=0`.
- `start` pulsed during RUN and DRAIN is ignored. `start` asserted together with `abort` in IDLE is ignored. Back-to-back frames of 3 beats each give `done` pulses 3+DRAIN_CYCLES+2 cycles apart when `start` is held high.

Source files
------------

// File: rtl/fir_filter_seq_ctrl_if.sv
// fir_filter_seq_ctrl_if
//   Bundles the frame-control and beat handshake between the sample source
//   (master) and the FIR input-control sequencer (slave).
//   Source -> sequencer : start, frame_len, abort, in_valid
//   Sequencer -> source : in_ready, cnt_mod, tc_write, tap_valid, tap_phase,
//                         busy, done
interface fir_filter_seq_ctrl_if #(
   parameter int LEN_W = 16
);
   logic             start;
   logic [LEN_W-1:0] frame_len;
   logic             abort;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       cnt_mod;
   logic             tc_write;
   logic             tap_valid;
   logic [1:0]       tap_phase;
   logic             busy;
   logic             done;

   modport master (
      output start, frame_len, abort, in_valid,
      input  in_ready, cnt_mod, tc_write, tap_valid, tap_phase, busy, done
   );

   modport slave (
      input  start, frame_len, abort, in_valid,
      output in_ready, cnt_mod, tc_write, tap_valid, tap_phase, busy, done
   );
endinterface

// File: rtl/fir_filter_seq_ctrl.sv
// fir_filter_seq_ctrl
//   Sequencer for the 3-phase FIR input-control datapath. Accepts a frame of
//   beats over a valid/ready handshake, steps the datapath phase select
//   (cnt_mod 0->1->2->0) and advance enable (tc_write) on every accepted beat,
//   flags each beat that completes the tap window (tap_valid/tap_phase), and
//   pulses done after a fixed drain following the last beat.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fir_filter_seq_ctrl_if.slave (frame control, beat handshake,
//            datapath controls and status)
// Parameters
//   LEN_W        : frame length / counter width
//   FILL_BEATS   : beats needed before the tap window is full (>= 1)
//   DRAIN_CYCLES : cycles waited after the last beat before done (0..15)
module fir_filter_seq_ctrl #(
   parameter int LEN_W        = 16,
   parameter int FILL_BEATS   = 3,
   parameter int DRAIN_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   fir_filter_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);
   localparam logic [LEN_W-1:0] FILL_CNT   = LEN_W'(FILL_BEATS);
   // DRAIN counts down to zero, so it is loaded with one less than its length.
   localparam logic [3:0]       DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 4'd0 : 4'(DRAIN_CYCLES - 1);

   state_t           state_q, state_d;
   logic [1:0]       cnt_mod_q, cnt_mod_d;
   logic [LEN_W-1:0] rem_q, rem_d;        // beats still to accept
   logic [LEN_W-1:0] acc_q, acc_d;        // beats accepted, saturates at FILL_BEATS
   logic [3:0]       drain_q, drain_d;
   logic             tap_valid_q, tap_fire;
   logic [1:0]       tap_phase_q, tap_phase_d;

   logic             in_ready;
   logic             accept;
   logic [LEN_W-1:0] acc_inc;

   // abort wins over an offered beat in the same cycle.
   assign in_ready = ((state_q == S_FILL) || (state_q == S_RUN)) && !bus.abort;
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_mod_q   <= 2'd0;
         rem_q       <= '0;
         acc_q       <= '0;
         drain_q     <= 4'd0;
         tap_valid_q <= 1'b0;
         tap_phase_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_mod_q   <= cnt_mod_d;
         rem_q       <= rem_d;
         acc_q       <= acc_d;
         drain_q     <= drain_d;
         tap_valid_q <= tap_fire;
         tap_phase_q <= tap_phase_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_mod_d   = cnt_mod_q;
      rem_d       = rem_q;
      acc_d       = acc_q;
      drain_d     = drain_q;
      tap_phase_d = tap_phase_q;
      tap_fire    = 1'b0;
      acc_inc     = (acc_q >= FILL_CNT) ? acc_q : acc_q + ONE;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.abort && (bus.frame_len != '0)) begin
               state_d   = S_FILL;
               rem_d     = bus.frame_len;
               acc_d     = '0;
               cnt_mod_d = 2'd0;
            end
         end
         S_FILL, S_RUN: begin
            if (accept) begin
               cnt_mod_d = (cnt_mod_q == 2'd2) ? 2'd0 : cnt_mod_q + 2'd1;
               rem_d     = rem_q - ONE;
               acc_d     = acc_inc;
               if (acc_inc >= FILL_CNT) begin
                  tap_fire    = 1'b1;
                  tap_phase_d = cnt_mod_q;
               end
               // Last beat can come straight from FILL on short frames.
               if (rem_q == ONE) begin
                  if (DRAIN_CYCLES == 0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_DRAIN;
                     drain_d = DRAIN_LOAD;
                  end
               end else if (acc_inc >= FILL_CNT) begin
                  state_d = S_RUN;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == 4'd0) state_d = S_DONE;
            else                 drain_d = drain_q - 4'd1;
         end
         S_DONE: begin
            state_d   = S_IDLE;
            cnt_mod_d = 2'd0;
            rem_d     = '0;
            acc_d     = '0;
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         cnt_mod_d = 2'd0;
         rem_d     = '0;
         acc_d     = '0;
         drain_d   = 4'd0;
         tap_fire  = 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.tc_write  = accept;
   assign bus.cnt_mod   = cnt_mod_q;
   assign bus.tap_valid = tap_valid_q;
   assign bus.tap_phase = tap_phase_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fir_filter_seq_ctrl.sv
// tb_fir_filter_seq_ctrl
//   Randomized frames against a frame-level reference model. The model tracks
//   only "idle / taking beats / waiting for done" and the beat index within the
//   frame; expected taps and done pulses are queued when beats are accepted and
//   popped by the monitor whenever the DUT presents them.
module tb_fir_filter_seq_ctrl;
   localparam int LW   = 16;
   localparam int FILL = 3;
   localparam int D    = 2;

   typedef struct {
      int cyc;
      int ph;
   } tap_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   fir_filter_seq_ctrl_if #(.LEN_W(LW)) bus ();

   fir_filter_seq_ctrl #(
      .LEN_W       (LW),
      .FILL_BEATS  (FILL),
      .DRAIN_CYCLES(D)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   bit   mon_en = 1'b0;

   // reference model
   int   m_phase   = 0;   // 0 idle, 1 taking beats, 2 waiting for done
   int   cur_len   = 0;
   int   cur_idx   = 0;
   int   m_done_at = 0;
   tap_t tap_q[$];
   int   done_q[$];

   int   tc_cnt    = 0;
   int   tap_cnt   = 0;
   int   done_cnt  = 0;
   int   done_cyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor + model, evaluated mid-cycle
   initial begin
      tap_t e;
      int   dc;
      bit   exp_rdy;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_phase = 0;
            cur_idx = 0;
            tap_q.delete();
            done_q.delete();
         end else if (mon_en) begin
            exp_rdy = (m_phase == 1) && !bus.abort;
            chk("busy", bus.busy, (m_phase != 0));
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("tc_write", bus.tc_write, exp_rdy && bus.in_valid);
            chk("cnt_mod", bus.cnt_mod, (m_phase == 0) ? 0 : cur_idx % 3);
            if (bus.tc_write) tc_cnt++;

            if (bus.tap_valid) begin
               tap_cnt++;
               if (tap_q.size() == 0) chk("tap_valid_unexpected", bus.tap_valid, 0);
               else begin
                  e = tap_q.pop_front();
                  chk("tap_cycle", cyc, e.cyc);
                  chk("tap_phase", bus.tap_phase, e.ph);
               end
            end else if (tap_q.size() != 0 && tap_q[0].cyc <= cyc) begin
               chk("tap_valid_missing", bus.tap_valid, 1);
               void'(tap_q.pop_front());
            end

            if (bus.done) begin
               done_cnt++;
               done_cyc.push_back(cyc);
               if (done_q.size() == 0) chk("done_unexpected", bus.done, 0);
               else begin
                  dc = done_q.pop_front();
                  chk("done_cycle", cyc, dc);
               end
            end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
               chk("done_missing", bus.done, 1);
               void'(done_q.pop_front());
            end

            case (m_phase)
               0: if (bus.start && !bus.abort && bus.frame_len != 0) begin
                     cur_len = int'(bus.frame_len);
                     cur_idx = 0;
                     m_phase = 1;
                  end
               1: if (bus.abort) begin
                     m_phase = 0;
                     cur_idx = 0;
                  end else if (bus.in_valid) begin
                     cur_idx++;
                     if (cur_idx >= FILL) tap_q.push_back('{cyc + 1, (cur_idx - 1) % 3});
                     if (cur_idx == cur_len) begin
                        m_done_at = cyc + D + 1;
                        done_q.push_back(m_done_at);
                        m_phase = 2;
                     end
                  end
               default: if (bus.abort) begin
                     m_phase = 0;
                     cur_idx = 0;
                     if (done_q.size() != 0) void'(done_q.pop_back());
                  end else if (cyc == m_done_at) begin
                     m_phase = 0;
                     cur_idx = 0;
                  end
            endcase
         end
      end
   end

   task automatic wait_idle(input bit poke);
      int n = 0;
      while (bus.busy && n < 200) begin
         if (poke) begin
            bus.start     = ($urandom_range(1) == 1);
            bus.frame_len = LW'($urandom_range(1, 9));
         end
         tick();
         n++;
      end
      bus.start = 1'b0;
      if (bus.busy) chk("idle_timeout", bus.busy, 0);
   endtask

   // bub < 0 : in_valid alternates high/low; otherwise percent chance of a bubble
   task automatic run_frame(input int len, input int bub, input int abort_beat, input bit poke);
      int acc = 0;
      int n   = 0;
      bit ab;
      bus.start     = 1'b1;
      bus.frame_len = LW'(len);
      tick();
      bus.start     = 1'b0;
      bus.frame_len = LW'($urandom);
      while (acc < len && n < 2000) begin
         if (bub < 0) bus.in_valid = (n % 2 == 0);
         else         bus.in_valid = ($urandom_range(99) >= 32'(bub));
         ab = (abort_beat > 0) && (acc == abort_beat - 1) && bus.in_valid;
         bus.abort = ab;
         if (poke) bus.start = ($urandom_range(3) == 0);
         if (!ab && bus.in_valid && bus.in_ready) acc++;
         tick();
         n++;
         if (ab) break;
      end
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
      bus.start    = 1'b0;
      if (n >= 2000) chk("frame_timeout", acc, len);
      wait_idle(poke);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
      $fatal(1);
   end

   initial begin
      int d0, t0, p0;
      bus.start     = 1'b0;
      bus.frame_len = '0;
      bus.abort     = 1'b0;
      bus.in_valid  = 1'b0;

      // reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_cnt_mod", bus.cnt_mod, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_tc_write", bus.tc_write, 0);
      chk("rst_tap_valid", bus.tap_valid, 0);
      chk("rst_tap_phase", bus.tap_phase, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      tick();
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // 7 beats, continuous
      t0 = tc_cnt; p0 = tap_cnt; d0 = done_cnt;
      run_frame(7, 0, 0, 1'b0);
      chk("f7_tc_count", tc_cnt - t0, 7);
      chk("f7_tap_count", tap_cnt - p0, 5);
      chk("f7_done_count", done_cnt - d0, 1);

      // 6 beats, in_valid every other cycle
      t0 = tc_cnt; p0 = tap_cnt; d0 = done_cnt;
      run_frame(6, -1, 0, 1'b0);
      chk("f6_tc_count", tc_cnt - t0, 6);
      chk("f6_tap_count", tap_cnt - p0, 4);
      chk("f6_done_count", done_cnt - d0, 1);

      // 2 beats: no taps
      p0 = tap_cnt; d0 = done_cnt;
      run_frame(2, 0, 0, 1'b0);
      chk("f2_tap_count", tap_cnt - p0, 0);
      chk("f2_done_count", done_cnt - d0, 1);

      // start with frame_len 0 is ignored
      d0 = done_cnt;
      bus.start = 1'b1; bus.frame_len = '0;
      tick();
      bus.start = 1'b0;
      tick();
      chk("len0_busy", bus.busy, 0);
      tick(); tick(); tick();
      chk("len0_done_count", done_cnt - d0, 0);

      // abort on the 4th accept of a 10-beat frame
      t0 = tc_cnt; d0 = done_cnt;
      run_frame(10, 0, 4, 1'b0);
      tick(); tick(); tick(); tick();
      chk("abort_tc_count", tc_cnt - t0, 3);
      chk("abort_done_count", done_cnt - d0, 0);
      chk("abort_cnt_mod", bus.cnt_mod, 0);

      // start pokes during RUN/DRAIN
      t0 = tc_cnt; d0 = done_cnt;
      run_frame(8, 20, 0, 1'b1);
      chk("poke_tc_count", tc_cnt - t0, 8);
      chk("poke_done_count", done_cnt - d0, 1);

      // start together with abort in IDLE
      bus.start = 1'b1; bus.abort = 1'b1; bus.frame_len = LW'(5);
      tick();
      bus.start = 1'b0; bus.abort = 1'b0;
      tick();
      chk("start_abort_busy", bus.busy, 0);

      // reset mid-frame with cnt_mod == 2
      bus.start = 1'b1; bus.frame_len = LW'(10);
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_reset_cnt_mod", bus.cnt_mod, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_cnt_mod", bus.cnt_mod, 0);
      chk("mrst_in_ready", bus.in_ready, 0);
      chk("mrst_tc_write", bus.tc_write, 0);
      chk("mrst_tap_valid", bus.tap_valid, 0);
      chk("mrst_tap_phase", bus.tap_phase, 0);
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_done", bus.done, 0);
      bus.in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      run_frame(4, 0, 0, 1'b0);

      // back-to-back 3-beat frames with start held high
      done_cyc.delete();
      bus.start = 1'b1; bus.frame_len = LW'(3); bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && done_cyc.size() < 3; i++) tick();
      bus.start = 1'b0; bus.in_valid = 1'b0;
      wait_idle(1'b0);
      if (done_cyc.size() < 3) chk("b2b_done_count", done_cyc.size(), 3);
      else begin
         chk("b2b_gap1", done_cyc[1] - done_cyc[0], 3 + D + 2);
         chk("b2b_gap2", done_cyc[2] - done_cyc[1], 3 + D + 2);
      end

      // randomized frames
      for (int f = 0; f < 15; f++) begin
         int len, bub, ab;
         bit poke;
         len  = int'($urandom_range(1, 12));
         bub  = int'($urandom_range(0, 50));
         ab   = ($urandom_range(4) == 0) ? int'($urandom_range(1, len)) : 0;
         poke = 1'($urandom_range(1));
         d0   = done_cnt;
         run_frame(len, bub, ab, poke);
         tick();
         chk("rand_done_count", done_cnt - d0, (ab != 0) ? 0 : 1);
      end

      tick(); tick(); tick(); tick();
      chk("tap_q_drained", tap_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
